// File: rtl/cc_branch_resolver.sv
// Condition-code register, in-flight CC-writer tracking and branch resolution for LC-3b.
// A branch waits until no CC writer is in flight, then resolves nzp against N/Z/P.
module cc_branch_resolver #(
   parameter int          PEND_W   = 3,
   parameter logic [2:0]  CC_RESET = 3'b010
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cc_issue,
   input  logic              ld_cc,
   input  logic [15:0]       cc_word,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [2:0]        br_nzp,
   input  logic [15:0]       br_pc,
   input  logic [8:0]        br_offset9,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_taken,
   output logic [15:0]       res_target,
   output logic              n,
   output logic              z,
   output logic              p,
   output logic [PEND_W-1:0] cc_pending,
   output logic              cc_ovf,
   output logic [1:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid-side payload is held stable until that transfer occurs.

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT_CC = 2'd1;
   localparam logic [1:0] S_RESOLVE = 2'd2;

   localparam logic [PEND_W-1:0] CNT_MAX = '1;
   localparam logic [PEND_W-1:0] CNT_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

   logic [2:0]        cc_q, cc_d;
   logic [PEND_W-1:0] cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [1:0]        state_q, state_d;
   logic [2:0]        nzp_q, nzp_d;
   logic              taken_q, taken_d;
   logic [15:0]       target_q, target_d;
   logic [15:0]       off_ext;

   assign off_ext = {{6{br_offset9[8]}}, br_offset9, 1'b0};

   always_comb begin
      cc_d = cc_q;
      if (ld_cc) begin
         if (cc_word[15])           cc_d = 3'b100;
         else if (cc_word == 16'h0) cc_d = 3'b010;
         else                       cc_d = 3'b001;
      end
   end

   // Saturating counter: no underflow at zero, overflow is recorded instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      case ({cc_issue, ld_cc})
         2'b10: begin
            if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_ONE;
         end
         2'b01: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      nzp_d    = nzp_q;
      taken_d  = taken_q;
      target_d = target_q;
      case (state_q)
         S_IDLE: begin
            if (br_valid) begin
               nzp_d    = br_nzp;
               target_d = br_pc + off_ext;
               if (br_nzp == 3'b111 || cnt_d == '0) begin
                  state_d = S_RESOLVE;
                  taken_d = |(br_nzp & cc_d);
               end else begin
                  state_d = S_WAIT_CC;
               end
            end
         end
         S_WAIT_CC: begin
            if (cnt_d == '0) begin
               state_d = S_RESOLVE;
               taken_d = |(nzp_q & cc_d);
            end
         end
         S_RESOLVE: begin
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cc_q     <= CC_RESET;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         state_q  <= S_IDLE;
         nzp_q    <= 3'b000;
         taken_q  <= 1'b0;
         target_q <= 16'h0000;
      end else begin
         cc_q     <= cc_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         nzp_q    <= nzp_d;
         taken_q  <= taken_d;
         target_q <= target_d;
      end
   end

   assign br_ready   = (state_q == S_IDLE);
   assign res_valid  = (state_q == S_RESOLVE);
   assign res_taken  = taken_q;
   assign res_target = target_q;
   assign n          = cc_q[2];
   assign z          = cc_q[1];
   assign p          = cc_q[0];
   assign cc_pending = cnt_q;
   assign cc_ovf     = ovf_q;
   assign dbg_state  = state_q;

endmodule
